psum_accum_buf: RTL and testbench
=================================

# psum_accum_buf

Partial-sum accumulation buffer placed directly downstream of the three-input psum adder. It accepts a stream of adder results, one per tile position, and accumulates them in place over a programmable number of passes. After the final pass it drains the finished sums to the output-feature-map writer through a valid/ready port. It provides the temporal accumulation the spatial adder tree cannot: same position, successive input-channel chunks.

## Interface
- DATA_BITWIDTH, 16, width of psum words (matches adder output)
- DEPTH, 16, number of psum entries (tile positions); power of two, ≥2
- ADDR_BITWIDTH, 4, log2(DEPTH)
- PASS_BITWIDTH, 8, width of pass-count config
- clk  input  1  clock; one clock domain, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a job; sampled only in IDLE
- cfg_pass_num  input  PASS_BITWIDTH  number of accumulation passes, latched on accepted start; 0 is treated as 1
- in_valid  input  1  adder result valid
- in_data  input  DATA_BITWIDTH  adder result
- in_ready  output  1  buffer accepts in_data this cycle
- out_valid  output  1  finished psum available
- out_data  output  DATA_BITWIDTH  finished psum at the read pointer
- out_ready  input  1  downstream consumes out_data
- busy  output  1  high in ACCUM or DRAIN
- done  output  1  one-cycle pulse on final drain handshake

## Operation
- States: IDLE, ACCUM, DRAIN.
- IDLE: in_ready=0, out_valid=0. On start, latch N=max(cfg_pass_num,1), set wp=0, rp=0, pass=0, and go to ACCUM.
- ACCUM: in_ready=1. On an in handshake, if pass==0 then mem[wp]←in_data (overwrite, no clear needed); otherwise mem[wp]←mem[wp]+in_data, truncated mod 2^DATA_BITWIDTH with no saturation. wp increments. At wp==DEPTH-1, wp wraps to 0 and pass increments. When that wrap completes pass N-1, go to DRAIN.
- DRAIN: in_ready=0, out_valid=1, out_data=mem[rp]. On an out handshake, rp increments. The handshake at rp==DEPTH-1 pulses done, sets rp to 0, and returns to IDLE.
- A start outside IDLE is ignored. in_valid outside ACCUM is ignored; no data is lost because in_ready=0 there.
- Reset at any point, mid-job included: state=IDLE, wp=rp=pass=0, all mem entries=0, latched N=1.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- start at cycle t gives busy=1 and in_ready=1 at t+1.
- The accumulate path is single cycle: a handshake at t updates mem[wp] at the t+1 edge. Back-to-back beats every cycle are supported with no bubbles. Each pass touches a distinct entry per beat, so there is no read-after-write hazard.
- The last ACCUM handshake at t gives out_valid=1 at t+1 with out_data=mem[0], already including that beat's contribution.
- in_ready, out_valid, and busy decode from registered state only. out_data is a mux of registered mem by registered rp, with no combinational path from inputs.
- The out port holds out_data stable while out_valid && !out_ready.
- Minimum job length: N·DEPTH accept cycles + DEPTH drain cycles + 1 start cycle.
- done is high for exactly the cycle after the final drain handshake edge, alongside busy=0. A start in that same cycle is accepted.

## Structure
- Shared accelerator package holds the state encoding (IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2) and the default DATA_BITWIDTH/DEPTH constants used by the adder and this buffer.
- One sub-module, psum_regfile: DEPTH×DATA_BITWIDTH flop array with synchronous reset, one write port and one asynchronous read port for the drain mux. The accumulate adder, FSM, and pointers stay in psum_accum_buf.

## Test plan
- DEPTH=4, cfg_pass_num=1, in_data 1,2,3,4 back to back → out_data 1,2,3,4 with out_ready=1; done pulses once; busy falls the same cycle.
- DEPTH=4, cfg_pass_num=3, each pass sends 10,20,30,40 → drain 30,60,90,120; in_ready=0 from the cycle after the 12th beat.
- Overflow: DATA_BITWIDTH=16, 2 passes of 16'hFFFF and 16'h0002 into entry 0 → drain 16'h0001 with no flag.
- Backpressure: out_ready toggles 0/1 randomly during drain → every value is presented exactly once and held stable while stalled; a start pulse during DRAIN is ignored.
- Reset asserted mid-ACCUM after 5 beats → next cycle IDLE with all outputs 0. A new job with cfg_pass_num=0 behaves as 1 pass, and results contain no stale data.
- in_valid toggling 1/0 per cycle during ACCUM → results match the gap-free run; in_valid=1 held in IDLE writes nothing.

Source files
------------

// File: rtl/psum_accum_buf_pkg.sv
// Shared accelerator definitions: buffer FSM encoding and default psum geometry
// used by the psum adder and the accumulation buffer.
package psum_accum_buf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PSUM_DATA_BITWIDTH = 16;
    localparam int PSUM_DEPTH         = 16;

endpackage

// File: rtl/psum_accum_buf_regfile.sv
// DEPTH x DATA_BITWIDTH psum storage: one synchronous write port, one
// asynchronous read port shared by the accumulate and drain paths.
module psum_regfile #(
    parameter int DATA_BITWIDTH = 16,
    parameter int DEPTH         = 16,
    parameter int ADDR_BITWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_BITWIDTH-1:0] waddr,
    input  logic [DATA_BITWIDTH-1:0] wdata,
    input  logic [ADDR_BITWIDTH-1:0] raddr,
    output logic [DATA_BITWIDTH-1:0] rdata
);

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    // Entries are cleared on reset so an aborted job leaves nothing behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/psum_accum_buf.sv
// Partial-sum accumulation buffer: accumulates N passes of DEPTH adder results
// in place, then drains the finished sums over a valid/ready port.
module psum_accum_buf
    import psum_accum_buf_pkg::*;
#(
    parameter int DATA_BITWIDTH = PSUM_DATA_BITWIDTH,
    parameter int DEPTH         = PSUM_DEPTH,
    parameter int ADDR_BITWIDTH = $clog2(DEPTH),
    parameter int PASS_BITWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_BITWIDTH-1:0] cfg_pass_num,
    input  logic                     in_valid,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_BITWIDTH-1:0] out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

    // Two's-complement wrap: overflow is silently truncated, never saturated.
    function automatic logic signed [DATA_BITWIDTH-1:0] wrap_add(
        input logic signed [DATA_BITWIDTH-1:0] a,
        input logic signed [DATA_BITWIDTH-1:0] b
    );
        return a + b;
    endfunction

    state_t                          state;
    logic [ADDR_BITWIDTH-1:0]        wp;
    logic [ADDR_BITWIDTH-1:0]        rp;
    logic [PASS_BITWIDTH-1:0]        pass;
    logic [PASS_BITWIDTH-1:0]        n_pass;
    logic                            done_r;

    logic                            in_hs;
    logic                            out_hs;
    logic [ADDR_BITWIDTH-1:0]        raddr;
    logic signed [DATA_BITWIDTH-1:0] rdata;
    logic signed [DATA_BITWIDTH-1:0] wdata;

    assign in_hs  = (state == ACCUM) && in_valid;
    assign out_hs = (state == DRAIN) && out_ready;

    // The single read port follows wp while accumulating and rp while draining.
    assign raddr = (state == DRAIN) ? rp : wp;
    assign wdata = (pass == '0) ? $signed(in_data) : wrap_add(rdata, $signed(in_data));

    psum_regfile #(
        .DATA_BITWIDTH(DATA_BITWIDTH),
        .DEPTH        (DEPTH),
        .ADDR_BITWIDTH(ADDR_BITWIDTH)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .we   (in_hs),
        .waddr(wp),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wp     <= '0;
            rp     <= '0;
            pass   <= '0;
            n_pass <= PASS_BITWIDTH'(1);
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_pass <= (cfg_pass_num == '0) ? PASS_BITWIDTH'(1) : cfg_pass_num;
                        wp     <= '0;
                        rp     <= '0;
                        pass   <= '0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_hs) begin
                        if (wp == LAST_ADDR) begin
                            wp   <= '0;
                            pass <= pass + 1'b1;
                            if (pass == n_pass - 1'b1) begin
                                state <= DRAIN;
                            end
                        end else begin
                            wp <= wp + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (rp == LAST_ADDR) begin
                            rp     <= '0;
                            done_r <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            rp <= rp + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign busy      = (state == ACCUM) || (state == DRAIN);
    assign done      = done_r;
    assign out_data  = (state == DRAIN) ? rdata : '0;

endmodule

// File: tb/tb_psum_accum_buf.sv
// Scoreboard bench for psum_accum_buf (DEPTH=4): directed jobs push expected
// drain values; a negedge monitor pops and compares every out handshake.
module tb_psum_accum_buf;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] cfg_pass_num;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] expq[$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held;
    logic [DW-1:0] exp_v;

    psum_accum_buf #(
        .DATA_BITWIDTH(DW),
        .DEPTH        (DEPTH),
        .ADDR_BITWIDTH(AW),
        .PASS_BITWIDTH(PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cfg_pass_num(cfg_pass_num),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected value per out handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) chk("hold_stable", out_data, held);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=none", out_data);
                end else begin
                    exp_v = expq.pop_front();
                    chk("out_data", out_data, exp_v);
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [DW-1:0] a, b, c, d);
        expq.push_back(a);
        expq.push_back(b);
        expq.push_back(c);
        expq.push_back(d);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"},  out_data,  '0);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_done"},      done,      1'b0);
    endtask

    task automatic start_job(input logic [PW-1:0] n);
        start        = 1'b1;
        cfg_pass_num = n;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("in_ready_after_start", in_ready, 1'b1);
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit gap);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic beats4(input logic [DW-1:0] a, b, c, d, input bit gap);
        beat(a, gap);
        beat(b, gap);
        beat(c, gap);
        beat(d, gap);
    endtask

    // Runs the drain; stops at the done cycle when stay_at_done is set.
    task automatic drain(input bit rnd, input bit poke_start, input bit stay_at_done);
        bit fin = 1'b0;
        for (int i = 0; i < 64 && !fin; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = poke_start && (i == 1);
            tick();
            start = 1'b0;
            if (done) begin
                fin = 1'b1;
                chk("busy_with_done", busy, 1'b0);
                chk("queue_empty_at_done", expq.size(), 0);
            end
        end
        out_ready = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=no_done required=done");
        end else if (!stay_at_done) begin
            tick();
            chk("done_single_cycle", done, 1'b0);
            chk("idle_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        cfg_pass_num = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Single pass, back to back.
        push4(16'd1, 16'd2, 16'd3, 16'd4);
        start_job(8'd1);
        beats4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        chk("t1_in_ready_low", in_ready, 1'b0);
        chk("t1_out_valid", out_valid, 1'b1);
        drain(1'b0, 1'b0, 1'b0);

        // Three passes.
        push4(16'd30, 16'd60, 16'd90, 16'd120);
        start_job(8'd3);
        for (int p = 0; p < 3; p++) beats4(16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
        chk("t2_in_ready_low", in_ready, 1'b0);
        chk("t2_out_valid", out_valid, 1'b1);
        drain(1'b0, 1'b0, 1'b0);

        // Wrap-around overflow in entry 0.
        push4(16'h0001, 16'h0001, 16'h0001, 16'h0001);
        start_job(8'd2);
        beats4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        beats4(16'h0002, 16'h0001, 16'h0001, 16'h0001, 1'b0);
        drain(1'b0, 1'b0, 1'b0);

        // Random backpressure with an ignored start during drain.
        push4(16'd5, 16'd6, 16'd7, 16'd8);
        start_job(8'd1);
        beats4(16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
        drain(1'b1, 1'b1, 1'b0);

        // Reset mid-accumulation, then a cfg_pass_num=0 job.
        start_job(8'd2);
        for (int i = 0; i < 5; i++) beat(16'd9, 1'b0);
        reset = 1'b1;
        tick();
        check_idle_outputs("midreset");
        reset = 1'b0;
        tick();
        push4(16'd11, 16'd12, 16'd13, 16'd14);
        start_job(8'd0);
        beats4(16'd11, 16'd12, 16'd13, 16'd14, 1'b0);
        chk("pass0_as_1_out_valid", out_valid, 1'b1);
        drain(1'b0, 1'b0, 1'b0);

        // in_valid held in IDLE is refused.
        in_valid = 1'b1;
        in_data  = 16'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;

        // Gapped input, then a start in the done cycle.
        push4(16'd2, 16'd4, 16'd6, 16'd8);
        start_job(8'd2);
        beats4(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        beats4(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        drain(1'b0, 1'b0, 1'b1);
        push4(16'd7, 16'd7, 16'd7, 16'd7);
        start_job(8'd1);
        beats4(16'd7, 16'd7, 16'd7, 16'd7, 1'b0);
        drain(1'b0, 1'b0, 1'b0);

        tick();
        chk("queue_drained", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
